mem_lsu: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered write-back triple (waddr, wdata, we), the ALU op, the effective address and the store data.
- Performs load/store transactions on a req/ack data bus and stalls the pipeline until each transaction completes.
- Produces the final write-back triple for the MEM/WB register. Non-memory ops pass through combinationally with zero added latency.

---
 rtl/mem_lsu_pkg.sv | 64 ++++++
 rtl/mem_lsu_align.sv | 60 ++++++
 rtl/mem_lsu.sv | 152 +++++++++++++++
 tb/tb_mem_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_pkg
// Purpose  : Shared load/store op codes, LSU state encoding and op decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_ADD_OP = 8'h20;
    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic acc_size_e op_size(input logic [7:0] op);
        if ((op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP)) begin
            return SZ_BYTE;
        end else if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP)) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        acc_size_e sz;
        sz = op_size(op);
        if (sz == SZ_HALF) begin
            return off[0];
        end else if (sz == SZ_WORD) begin
            return off != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Big-endian lane select, store replication and load extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        lane_b  = 8'h00;
        lane_h  = 16'h0000;
        sext    = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LH_OP);
        sel_o   = 4'b1111;
        wdata_o = sdata_i;
        ldata_o = rdata_i;

        // offset 0 is the most significant byte on this bus
        case (offset_i)
            2'd0:    lane_b = rdata_i[31:24];
            2'd1:    lane_b = rdata_i[23:16];
            2'd2:    lane_b = rdata_i[15:8];
            default: lane_b = rdata_i[7:0];
        endcase
        lane_h = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (op_size(aluop_i))
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> offset_i;
                wdata_o = {4{sdata_i[7:0]}};
                ldata_o = {{24{sext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                sel_o   = offset_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{sdata_i[15:0]}};
                ldata_o = {{16{sext & lane_h[15]}}, lane_h};
            end
            default: begin
                sel_o   = 4'b1111;
                wdata_o = sdata_i;
                ldata_o = rdata_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : MEM stage load/store unit on a req/ack bus; stalls until ack.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_we_i,
    input  logic [7:0]        mem_aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_sdata_i,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_sel_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    input  logic              dbus_ack_i,
    output logic [4:0]        wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_we_o,
    output logic              stallreq_o,
    output logic              misalign_o
);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;

    logic        op_load;
    logic        op_store;
    logic        op_mem;
    logic        op_misaligned;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;

    assign op_load       = is_load(mem_aluop_i);
    assign op_store      = is_store(mem_aluop_i);
    assign op_mem        = op_load | op_store;
    assign op_misaligned = is_misaligned(mem_aluop_i, mem_addr_i[1:0]);

    lsu_align u_align (
        .aluop_i  (mem_aluop_i),
        .offset_i (mem_addr_i[1:0]),
        .sdata_i  (mem_sdata_i),
        .rdata_i  (dbus_rdata_i),
        .sel_o    (al_sel),
        .wdata_o  (al_wdata),
        .ldata_o  (al_ldata)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        wb_waddr_o = mem_waddr_i;
        wb_wdata_o = mem_wdata_i;
        wb_we_o    = mem_we_i;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                // Memory ops never write back from IDLE: either faulted or still in flight
                if (op_mem && !rst) begin
                    wb_we_o = 1'b0;
                    if (op_misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                        req_d      = 1'b1;
                        we_d       = op_store;
                        addr_d     = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        sel_d      = al_sel;
                        wdata_d    = al_wdata;
                        state_d    = LSU_BUSY;
                    end
                end
            end
            LSU_BUSY: begin
                stallreq_o = 1'b1;
                wb_we_o    = 1'b0;
                if (dbus_ack_i) begin
                    if (op_load) begin
                        ldata_d = al_ldata;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    sel_d   = 4'b0000;
                    wdata_d = ZeroWord;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (op_load) begin
                    wb_wdata_o = ldata_q;
                end
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= ZeroWord;
            ldata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
        end
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_sel_o   = sel_q;
    assign dbus_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Scoreboard bench for mem_lsu: directed load/store/passthrough vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_we_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic [31:0] dbus_rdata_i;
    logic        dbus_ack_i;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_we_o;
    logic        stallreq_o;
    logic        misalign_o;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_waddr_i  (mem_waddr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_we_i     (mem_we_i),
        .mem_aluop_i  (mem_aluop_i),
        .mem_addr_i   (mem_addr_i),
        .mem_sdata_i  (mem_sdata_i),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_sel_o   (dbus_sel_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_ack_i   (dbus_ack_i),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .wb_we_o      (wb_we_o),
        .stallreq_o   (stallreq_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk_wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic        chk_wd;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int       total = 0;
    int       bad   = 0;
    logic     prev_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: bus attributes on every request cycle, write-back in the cycle req falls
    always @(negedge clk) begin
        bus_exp_t be;
        wb_exp_t  we;
        if (dbus_req_o) begin
            if (bus_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected: got req=1 want req=0");
            end else begin
                be = bus_q[0];
                chk("bus_we",   {31'd0, dbus_we_o}, {31'd0, be.we});
                chk("bus_addr", dbus_addr_o, be.addr);
                chk("bus_sel",  {28'd0, dbus_sel_o}, {28'd0, be.sel});
                if (be.chk_wd) chk("bus_wdata", dbus_wdata_o, be.wdata);
            end
        end
        if (prev_req && !dbus_req_o && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
            if (!rst) begin
                if (wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got completion want none");
                end else begin
                    we = wb_q.pop_front();
                    chk("done_wb_we", {31'd0, wb_we_o}, {31'd0, we.we});
                    chk("done_stall", {31'd0, stallreq_o}, 32'd0);
                    if (we.chk_wd) chk("done_wb_wdata", wb_wdata_o, we.wdata);
                end
            end
        end
        prev_req = dbus_req_o;
    end

    task automatic drive(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] wd,
                         input logic wen, input logic [31:0] ad, input logic [31:0] sd);
        mem_aluop_i = op;
        mem_waddr_i = wa;
        mem_wdata_i = wd;
        mem_we_i    = wen;
        mem_addr_i  = ad;
        mem_sdata_i = sd;
    endtask

    task automatic mem_txn(input string nm, input logic [7:0] op, input logic [31:0] ad,
                           input logic [31:0] sd, input logic [31:0] rd, input int ack_dly,
                           input logic st, input logic [3:0] sel, input logic [31:0] bwd,
                           input logic [31:0] wbd);
        int   stalls;
        int   nreq;
        logic done;
        bus_q.push_back('{we: st, addr: (ad & 32'hFFFF_FFFC), sel: sel, wdata: bwd, chk_wd: st});
        wb_q.push_back('{wdata: wbd, we: !st, chk_wd: !st});
        drive(op, 5'd9, 32'h0000_DEAD, !st, ad, sd);
        dbus_rdata_i = rd;
        stalls = 0;
        nreq   = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (dbus_req_o) begin
                nreq++;
                if (nreq == ack_dly) dbus_ack_i = 1'b1;
            end else if (nreq > 0) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            dbus_ack_i = 1'b0;
        end
        chk({nm, "_completed"}, {31'd0, done}, 32'd1);
        chk({nm, "_stall_cycles"}, stalls, ack_dly + 1);
        drive(EXE_NOP_OP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'd0;
        drive(EXE_NOP_OP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, dbus_req_o}, 32'd0);
        chk("rst_we",    {31'd0, dbus_we_o}, 32'd0);
        chk("rst_addr",  dbus_addr_o, 32'd0);
        chk("rst_sel",   {28'd0, dbus_sel_o}, 32'd0);
        chk("rst_wdata", dbus_wdata_o, 32'd0);
        chk("rst_wb",    {26'd0, wb_we_o, wb_waddr_o}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_mis",   {31'd0, misalign_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD passes through in the same cycle
        drive(EXE_ADD_OP, 5'd3, 32'h0000_1234, 1'b1, 32'h0000_0999, 32'd0);
        #1;
        chk("add_waddr", {27'd0, wb_waddr_o}, 32'd3);
        chk("add_wdata", wb_wdata_o, 32'h0000_1234);
        chk("add_we",    {31'd0, wb_we_o}, 32'd1);
        chk("add_stall", {31'd0, stallreq_o}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("add_noreq", {31'd0, dbus_req_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        mem_txn("lb",  EXE_LB_OP,  32'h0000_0101, 32'd0, 32'h11F2_3344, 2, 1'b0, 4'b0100, 32'd0, 32'hFFFF_FFF2);
        mem_txn("lhu", EXE_LHU_OP, 32'h0000_0202, 32'd0, 32'hAAAA_8001, 1, 1'b0, 4'b0011, 32'd0, 32'h0000_8001);
        mem_txn("sb",  EXE_SB_OP,  32'h0000_0003, 32'h0000_00A5, 32'd0, 1, 1'b1, 4'b0001, 32'hA5A5_A5A5, 32'd0);
        mem_txn("lh",  EXE_LH_OP,  32'h0000_0200, 32'd0, 32'h8123_4567, 2, 1'b0, 4'b1100, 32'd0, 32'hFFFF_8123);
        mem_txn("sh",  EXE_SH_OP,  32'h0000_0012, 32'h0000_BEEF, 32'd0, 3, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'd0);
        mem_txn("lw",  EXE_LW_OP,  32'h0000_0040, 32'd0, 32'h1357_9BDF, 1, 1'b0, 4'b1111, 32'd0, 32'h1357_9BDF);
        mem_txn("lbu", EXE_LBU_OP, 32'h0000_0007, 32'd0, 32'h0000_00C3, 1, 1'b0, 4'b0001, 32'd0, 32'h0000_00C3);
        mem_txn("sw",  EXE_SW_OP,  32'h0000_0020, 32'h0BAD_F00D, 32'd0, 2, 1'b1, 4'b1111, 32'h0BAD_F00D, 32'd0);

        // Misaligned LW: flagged, no write-back, no bus, no stall, stays idle
        drive(EXE_LW_OP, 5'd3, 32'h0000_0077, 1'b1, 32'h0000_0006, 32'd0);
        #1;
        chk("mis_lw_flag",  {31'd0, misalign_o}, 32'd1);
        chk("mis_lw_we",    {31'd0, wb_we_o}, 32'd0);
        chk("mis_lw_stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        chk("mis_lw_noreq", {31'd0, dbus_req_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("mis_lw_idle",  {31'd0, misalign_o}, 32'd1);
        chk("mis_lw_noreq2", {31'd0, dbus_req_o}, 32'd0);
        drive(EXE_SH_OP, 5'd0, 32'd0, 1'b0, 32'h0000_0005, 32'h0000_1111);
        #1;
        chk("mis_sh_flag",  {31'd0, misalign_o}, 32'd1);
        chk("mis_sh_stall", {31'd0, stallreq_o}, 32'd0);
        drive(EXE_LB_OP, 5'd4, 32'd0, 1'b1, 32'h0000_0005, 32'd0);
        #1;
        chk("lb_odd_nomis", {31'd0, misalign_o}, 32'd0);
        chk("lb_odd_stall", {31'd0, stallreq_o}, 32'd1);
        drive(EXE_NOP_OP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;

        // SW aborted by reset while waiting for ack
        bus_q.push_back('{we: 1'b1, addr: 32'h0000_0010, sel: 4'b1111, wdata: 32'hCAFE_BABE, chk_wd: 1'b1});
        drive(EXE_SW_OP, 5'd0, 32'h0000_DEAD, 1'b0, 32'h0000_0010, 32'hCAFE_BABE);
        @(negedge clk);
        chk("abort_idle_stall", {31'd0, stallreq_o}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_busy_req", {31'd0, dbus_req_o}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(EXE_NOP_OP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_req",   {31'd0, dbus_req_o}, 32'd0);
        chk("abort_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(EXE_ADD_OP, 5'd7, 32'h0000_5555, 1'b1, 32'd0, 32'd0);
        dbus_ack_i = 1'b1;
        @(negedge clk);
        chk("stray_req",   {31'd0, dbus_req_o}, 32'd0);
        chk("stray_stall", {31'd0, stallreq_o}, 32'd0);
        chk("stray_wb",    wb_wdata_o, 32'h0000_5555);
        @(posedge clk);
        #1;
        dbus_ack_i = 1'b0;
        @(negedge clk);
        chk("stray_req2", {31'd0, dbus_req_o}, 32'd0);
        chk("stray_we2",  {31'd0, wb_we_o}, 32'd1);
        @(posedge clk);
        #1;

        mem_txn("lb_after", EXE_LB_OP, 32'h0000_0100, 32'd0, 32'h8000_0000, 1, 1'b0, 4'b1000, 32'd0, 32'hFFFF_FF80);

        repeat (2) @(posedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("wb_q_empty",  wb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
